sha3_run_arbiter: RTL and testbench

Shares one power/activity budget slot between NumReq SHA3 engines. Each engine raises run_req_o before firing its Keccak rounds. The arbiter returns run_ack to exactly one requester at a time, using round-robin fairness. It enforces a quiet gap between grants, flags requesters that hold the grant too long, and locks out all grants on life-cycle escalation or FSM corruption.

---
 rtl/sha3_run_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sha3_run_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_run_arbiter.sv
// sha3_run_arbiter: round-robin grant of one shared activity slot among NumReq SHA3 engines.
// Latency: run_ack_o rises 1 cycle after a request is sampled; drops 1 cycle after that request falls.
// Backpressure: losing requests simply stay pending (never dropped) through a grant and the quiet gap.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   run_req_i            per-engine request, held until the engine's Keccak rounds complete
//   run_ack_o            one-hot-or-zero grant, decoded from state flops only
//   busy_o               a grant or the quiet gap is in progress
//   grant_idx_o          index of the current / last granted engine
//   lc_escalate_en_i     life-cycle escalation (anything but Off locks the arbiter)
//   hold_timeout_o       one-cycle pulse when a grant has been held MaxHoldCycles cycles
//   sparse_fsm_error_o   arbiter is in the terminal Error state
module sha3_run_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned QuietCycles   = 2,
    parameter int unsigned MaxHoldCycles = 64,
    localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] run_req_i,
    output logic [NumReq-1:0] run_ack_o,
    output logic              busy_o,
    output logic [IdxW-1:0]   grant_idx_o,
    input  logic [3:0]        lc_escalate_en_i,
    output logic              hold_timeout_o,
    output logic              sparse_fsm_error_o
);
    localparam int unsigned       HoldW     = $clog2(MaxHoldCycles + 1);
    localparam logic [HoldW-1:0]  HoldMax   = HoldW'(MaxHoldCycles);
    localparam logic [3:0]        QuietLast = (QuietCycles > 0) ? 4'(QuietCycles - 1) : 4'd0;
    localparam int unsigned       SumW      = IdxW + 1;
    localparam logic [SumW-1:0]   NumReqS   = SumW'(NumReq);
    localparam logic [NumReq-1:0] OneHot0   = NumReq'(1);
    localparam logic [3:0]        LcOff     = 4'b1010;

    // Pairwise Hamming distance >= 3 so a single upset cannot land on another valid state.
    typedef enum logic [4:0] {
        StIdle    = 5'b00111,
        StGranted = 5'b11001,
        StQuiet   = 5'b01010,
        StError   = 5'b10100
    } state_e;

    // Held as raw bits so that corrupted (non-enum) codes stay representable and detectable.
    logic [4:0]        state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]        quiet_cnt_q, quiet_cnt_d;
    logic              hold_timeout_q, hold_timeout_d;

    logic              escalate;
    logic              grant_req;
    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   rr_next;
    logic [NumReq-1:0] req_rot;
    logic [NumReq-1:0] grant_vec;
    logic [SumW-1:0]   pick_off;
    logic [SumW-1:0]   pick_sum;
    logic [SumW-1:0]   rr_sum;

    // Loose test: every encoding other than Off counts as escalation.
    assign escalate  = (lc_escalate_en_i != LcOff);
    assign grant_vec = OneHot0 << grant_q;
    assign grant_req = |(run_req_i & grant_vec);

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit,
    // then rotate the offset back into an absolute index.
    always_comb begin
        req_rot  = NumReq'({run_req_i, run_req_i} >> rr_ptr_q);
        pick_off = '0;
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = SumW'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + pick_off;
        if (pick_sum >= NumReqS) begin
            pick_sum = pick_sum - NumReqS;
        end
        pick_idx = pick_sum[IdxW-1:0];
        pick_vld = |run_req_i;

        rr_sum = {1'b0, grant_q} + SumW'(1);
        if (rr_sum >= NumReqS) begin
            rr_sum = '0;
        end
        rr_next = rr_sum[IdxW-1:0];
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        hold_cnt_d     = hold_cnt_q;
        quiet_cnt_d    = quiet_cnt_q;
        hold_timeout_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d    = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = StGranted;
                end
            end
            StGranted: begin
                if (!grant_req) begin
                    rr_ptr_d    = rr_next;
                    hold_cnt_d  = '0;
                    quiet_cnt_d = '0;
                    state_d     = (QuietCycles > 0) ? StQuiet : StIdle;
                end else if (hold_cnt_q != HoldMax) begin
                    // Saturating count; the overrun is only reported, the grant stays.
                    hold_cnt_d     = hold_cnt_q + HoldW'(1);
                    hold_timeout_d = (hold_cnt_q == HoldMax - HoldW'(1));
                end
            end
            StQuiet: begin
                // The last quiet cycle arbitrates directly, so exactly QuietCycles
                // ack-free cycles separate consecutive grants.
                if (quiet_cnt_q == QuietLast) begin
                    if (pick_vld) begin
                        grant_d    = pick_idx;
                        hold_cnt_d = '0;
                        state_d    = StGranted;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    quiet_cnt_d = quiet_cnt_q + 4'd1;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase

        if (escalate) begin
            state_d        = StError;
            hold_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            hold_cnt_q     <= '0;
            quiet_cnt_q    <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            quiet_cnt_q    <= quiet_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    // All outputs decode flops only; the async reset of state_q clears the ack immediately.
    assign run_ack_o          = (state_q == StGranted) ? grant_vec : '0;
    assign busy_o             = (state_q == StGranted) || (state_q == StQuiet);
    assign grant_idx_o        = grant_q;
    assign hold_timeout_o     = hold_timeout_q;
    assign sparse_fsm_error_o = (state_q == StError);

endmodule

// File: tb/tb_sha3_run_arbiter.sv
module tb_sha3_run_arbiter;
    localparam int N  = 4;
    localparam int Q  = 2;
    localparam int MH = 64;
    localparam logic [3:0] LC_ON  = 4'b0101;
    localparam logic [3:0] LC_OFF = 4'b1010;

    logic         clk_i  = 1'b0;
    logic         rst_ni = 1'b1;
    logic [N-1:0] run_req_i = '0;
    logic [3:0]   lc_escalate_en_i = LC_OFF;
    logic [N-1:0] run_ack_o;
    logic         busy_o;
    logic [1:0]   grant_idx_o;
    logic         hold_timeout_o;
    logic         sparse_fsm_error_o;

    sha3_run_arbiter #(.NumReq(N), .QuietCycles(Q), .MaxHoldCycles(MH)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .run_req_i          (run_req_i),
        .run_ack_o          (run_ack_o),
        .busy_o             (busy_o),
        .grant_idx_o        (grant_idx_o),
        .lc_escalate_en_i   (lc_escalate_en_i),
        .hold_timeout_o     (hold_timeout_o),
        .sparse_fsm_error_o (sparse_fsm_error_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    // owner: engine holding the slot (-1 none); gap: quiet cycles still owed.
    int m_owner = -1;
    int m_gap   = 0;
    int m_hold  = 0;
    int m_ptr   = 0;
    int m_idx   = 0;
    bit m_dead  = 0;
    bit m_to    = 0;
    int corrupt_req  = 0;
    int corrupt_seen = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_owner = -1; m_gap = 0; m_hold = 0; m_ptr = 0; m_idx = 0;
            m_dead = 0; m_to = 0; corrupt_seen = corrupt_req;
        end else begin
            m_to = 0;
            if (m_dead) begin
                m_owner = -1;
            end else if (lc_escalate_en_i != LC_OFF || corrupt_req != corrupt_seen) begin
                m_dead = 1; m_owner = -1; m_gap = 0;
            end else if (m_owner >= 0) begin
                if (!run_req_i[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_hold = 0; m_owner = -1; m_gap = Q;
                end else if (m_hold < MH) begin
                    m_hold++;
                    m_to = (m_hold == MH);
                end
            end else if (m_gap > 1) begin
                m_gap--;
            end else begin
                m_gap = 0;
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && run_req_i[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N; m_idx = m_owner; m_hold = 0;
                    end
                end
            end
            corrupt_seen = corrupt_req;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic cycle();
        @(negedge clk_i);
        chk("model ack",  int'(run_ack_o), (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("model busy", int'(busy_o), int'(!m_dead && (m_owner >= 0 || m_gap > 0)));
        chk("model idx",  int'(grant_idx_o), m_idx);
        chk("model timeout", int'(hold_timeout_o), int'(m_to));
        chk("model error", int'(sparse_fsm_error_o), int'(m_dead));
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic wait_ack(input string nm, input int exp_idx);
        int n = 0;
        while (run_ack_o == '0 && n < 20) begin
            cycle();
            n++;
        end
        if (run_ack_o == '0) chk({nm, " ack timeout"}, 0, 1);
        else chk(nm, onehot_idx(run_ack_o), exp_idx);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        run_req_i = '0;
        lc_escalate_en_i = LC_OFF;
        cycle();
        cycle();
        rst_ni = 1'b1;
        cycle();
    endtask

    initial begin
        int rises, last_fall, cur, rise_cyc, ack_cnt, pulses, pulse_c, any_ack;
        logic [N-1:0] prev;

        #1 rst_ni = 1'b0;
        cycle();
        // reset values
        chk("reset ack", int'(run_ack_o), 0);
        chk("reset busy", int'(busy_o), 0);
        chk("reset idx", int'(grant_idx_o), 0);
        chk("reset timeout", int'(hold_timeout_o), 0);
        chk("reset error", int'(sparse_fsm_error_o), 0);
        rst_ni = 1'b1;
        cycle();

        // single request held 5 cycles: ack t1..t5, busy t1..t7
        run_req_i = 4'b0010;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            chk("t1 ack1", int'(run_ack_o[1]), int'(k <= 5));
            chk("t1 busy", int'(busy_o), int'(k <= 7));
            if (k == 5) run_req_i = '0;
        end
        chk("t1 idx held", int'(grant_idx_o), 1);

        // service req[2] (pointer moves to 3), then req[0]+req[3] together
        run_req_i = 4'b0100;
        wait_ack("svc2", 2);
        run_req_i = '0;
        repeat (4) cycle();
        run_req_i = 4'b1001;
        wait_ack("rr 3 before 0", 3);
        run_req_i[3] = 1'b0;
        cycle();
        cycle();
        wait_ack("rr then 0", 0);
        run_req_i = '0;
        repeat (4) cycle();

        // round robin with all engines busy; each drops 3 cycles after its ack
        do_reset();
        run_req_i = 4'b1111;
        rises = 0; last_fall = 0; cur = 0; rise_cyc = 0; prev = '0;
        for (int c = 0; c < 200 && rises < 5; c++) begin
            cycle();
            if (run_ack_o != '0 && prev == '0) begin
                cur = onehot_idx(run_ack_o);
                chk("rr order", cur, rises % N);
                if (rises > 0) chk("rr quiet gap", c - last_fall, Q);
                rise_cyc = c;
                rises++;
            end else if (run_ack_o == '0 && prev != '0) begin
                last_fall = c;
                run_req_i[cur] = 1'b1;
            end
            if (run_ack_o != '0 && c == rise_cyc + 3) run_req_i[cur] = 1'b0;
            prev = run_ack_o;
        end
        if (rises < 5) chk("rr grants", rises, 5);
        run_req_i = '0;
        repeat (8) cycle();

        // hold overrun: req[0] held 100 cycles
        run_req_i = 4'b0001;
        ack_cnt = 0; pulses = 0; pulse_c = -1;
        for (int c = 0; c < 105; c++) begin
            cycle();
            if (run_ack_o[0]) ack_cnt++;
            if (hold_timeout_o) begin
                pulses++;
                pulse_c = c;
            end
            if (c == 99) run_req_i = '0;
        end
        chk("timeout pulses", pulses, 1);
        chk("timeout offset", pulse_c, 64);
        chk("ack kept after timeout", ack_cnt, 100);

        // escalation while ack[2] is high
        run_req_i = 4'b0100;
        wait_ack("esc grant", 2);
        lc_escalate_en_i = LC_ON;
        cycle();
        chk("esc ack", int'(run_ack_o), 0);
        chk("esc error", int'(sparse_fsm_error_o), 1);
        lc_escalate_en_i = LC_OFF;
        run_req_i = 4'b1111;
        any_ack = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (run_ack_o != '0) any_ack++;
        end
        chk("esc lockout", any_ack, 0);
        chk("esc terminal", int'(sparse_fsm_error_o), 1);
        do_reset();
        chk("esc recovered", int'(sparse_fsm_error_o), 0);

        // corrupted state register
        run_req_i = 4'b0010;
        wait_ack("corrupt grant", 1);
        #2;
        force dut.state_q = 5'b11111;
        corrupt_req++;
        #1;
        release dut.state_q;
        cycle();
        chk("corrupt error", int'(sparse_fsm_error_o), 1);
        chk("corrupt ack", int'(run_ack_o), 0);
        do_reset();

        // reset in the middle of a grant clears the ack asynchronously
        run_req_i = 4'b1000;
        wait_ack("arst grant", 3);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst ack", int'(run_ack_o), 0);
        chk("arst busy", int'(busy_o), 0);
        cycle();
        rst_ni = 1'b1;
        run_req_i = '0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
